instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Producer side of the 32-bit instruction word consumed by the controller/decoder.
//  Holds the PC, fetches words over a req/ack instruction-memory port, and presents
//  each word with valid/ready to the decoder. Accepts branch/jump redirects from
//  the execute side and squashes wrong-path fetches. Times out stuck fetches.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC loaded on reset; bits [1:0] must be 0
//  MAX_WAIT  15             cycles imem_req may stay unacked before fetch_err (1..255)
// PORTS
//  CLOCK           in   1   single clock, all state updates on posedge
//  RESET           in   1   synchronous, active-high
//  imem_req        out  1   fetch request, held high until imem_ack
//  imem_addr       out  32  word address, stable while imem_req=1
//  imem_ack        in   1   read data valid this cycle; ignored when imem_req=0
//  imem_rdata      in   32  instruction word, sampled when imem_req&imem_ack
//  instruction     out  32  word to decoder
//  instr_pc        out  32  address of `instruction`
//  instr_valid     out  1   instruction/instr_pc valid
//  instr_ready     in   1   decoder accepts word when instr_valid&instr_ready
//  redirect_valid  in   1   one-cycle redirect (taken branch / jump / jr)
//  redirect_pc     in   32  redirect target; bits [1:0] forced to 0
//  fetch_err       out  1   sticky timeout flag, cleared only by RESET
// BEHAVIOUR
//  Reset (RESET=1 at posedge): pc=RESET_PC, state=FETCH, imem_req=0,
//   imem_addr=RESET_PC, instruction=32'h0 (nop), instr_pc=0, instr_valid=0,
//   fetch_err=0, wait_cnt=0. First imem_req=1 the cycle after RESET falls.
//   RESET mid-fetch drops imem_req immediately; a later ack is ignored.
//  States: FETCH, HOLD, SQUASH, ERROR.
//  FETCH: imem_req=1, imem_addr=pc. On ack: instruction<=imem_rdata,
//   instr_pc<=pc, instr_valid<=1, pc<=pc+4 (mod 2^32, FFFF_FFFC->0000_0000),
//   imem_req<=0, ->HOLD. Fetch latency = ack latency + 1 (registered output).
//  HOLD: imem_req=0; instruction/instr_pc stable while instr_valid&!instr_ready.
//   On instr_ready: instr_valid<=0, ->FETCH (next req following cycle; peak
//   throughput 1 word / 2 cycles with zero-wait memory).
//  Redirect (highest priority, any state except ERROR):
//   HOLD: instr_valid<=0 (word squashed even if instr_ready=1 same cycle),
//    pc<=redirect_pc, ->FETCH.
//   FETCH with ack same cycle: rdata discarded, pc<=redirect_pc, ->FETCH
//    (imem_req drops 1 cycle, then new request).
//   FETCH without ack: req/addr held (protocol), pc<=redirect_pc, ->SQUASH.
//   SQUASH: imem_req=1 at old addr; on ack discard rdata, ->FETCH with new pc.
//    A further redirect in SQUASH overwrites pc; stays SQUASH.
//  Timeout: wait_cnt increments each cycle imem_req=1 & !imem_ack, clears on ack
//   or req=0. When wait_cnt reaches MAX_WAIT: fetch_err<=1, imem_req<=0,
//   instr_valid<=0, ->ERROR. ERROR: all outputs static, redirects ignored.
//  instr_valid never asserted for a squashed or discarded word.
// TESTING
//  1 Reset, RESET_PC=0x100, 0-wait mem returns addr-tagged words, ready=1 ->
//    instr_pc 0x100,0x104,0x108 in order, one valid every 2 cycles.
//  2 Hold ready=0 for 5 cycles with word 0x2009_0005 valid -> instruction,
//    instr_pc unchanged, imem_req=0 throughout; accepted on ready=1.
//  3 Redirect to 0x400 while FETCH with ack delayed 3 cycles -> addr stays old
//    until ack, old data never valid, next req addr=0x400.
//  4 Redirect in HOLD same cycle as instr_ready=1 -> word dropped, next
//    instr_pc=redirect target; redirect_pc=0x403 fetches 0x400.
//  5 PC=0xFFFF_FFFC fetched -> next imem_addr=0x0000_0000.
//  6 Never ack, MAX_WAIT=15 -> fetch_err=1 after 15 wait cycles, imem_req=0;
//    RESET clears fetch_err and restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Fetch-unit bundle: instruction-memory port, decoder port, redirect input and error flag.
// The fetch unit is the master; memory, decoder and execute side form the slave.
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_err;

  modport master (
    output imem_req, imem_addr, instruction, instr_pc, instr_valid, fetch_err,
    input  imem_ack, imem_rdata, instr_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instruction, instr_pc, instr_valid, fetch_err,
    output imem_ack, imem_rdata, instr_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC, req/ack fetch, valid/ready hand-off to the decoder,
// redirect squashing and a sticky timeout for memory that never answers.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 32'd15
) (
  input  logic          i_clk,
  input  logic          i_rst,
  instr_fetch_if.master bus
);
  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_HOLD   = 2'd1,
    S_SQUASH = 2'd2,
    S_ERROR  = 2'd3
  } state_t;

  // Timeout fires on the stalled cycle that would bring the count to MAX_WAIT.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 32'd1);

  state_t      r_state, w_state;
  logic [31:0] r_pc, w_pc;
  logic [31:0] r_addr, w_addr;
  logic [31:0] r_instr, w_instr;
  logic [31:0] r_instr_pc, w_instr_pc;
  logic        r_req, w_req;
  logic        r_valid, w_valid;
  logic        r_err, w_err;
  logic [7:0]  r_wait_cnt, w_wait_cnt;
  logic [31:0] w_redir_pc;
  logic        w_ack, w_stall, w_timeout;

  // Next-state and next-output logic.
  always_comb begin
    w_redir_pc = bus.redirect_pc & 32'hFFFF_FFFC;
    w_ack      = r_req & bus.imem_ack;
    w_stall    = r_req & ~bus.imem_ack;
    w_timeout  = w_stall & (r_wait_cnt == WAIT_LAST);
    w_state    = r_state;
    w_pc       = r_pc;
    w_addr     = r_addr;
    w_instr    = r_instr;
    w_instr_pc = r_instr_pc;
    w_req      = r_req;
    w_valid    = r_valid;
    w_err      = r_err;
    if (w_stall) begin
      w_wait_cnt = r_wait_cnt + 8'd1;
    end else begin
      w_wait_cnt = 8'd0;
    end

    if (w_timeout) begin
      w_err      = 1'b1;
      w_req      = 1'b0;
      w_valid    = 1'b0;
      w_wait_cnt = 8'd0;
      w_state    = S_ERROR;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (!r_req) begin
            // Issue cycle: request goes out at the (possibly redirected) pc.
            w_req  = 1'b1;
            w_pc   = bus.redirect_valid ? w_redir_pc : r_pc;
            w_addr = w_pc;
          end else if (w_ack) begin
            w_req = 1'b0;
            if (bus.redirect_valid) begin
              w_pc = w_redir_pc;
            end else begin
              w_instr    = bus.imem_rdata;
              w_instr_pc = r_addr;
              w_valid    = 1'b1;
              w_pc       = r_addr + 32'd4;
              w_state    = S_HOLD;
            end
          end else if (bus.redirect_valid) begin
            w_pc    = w_redir_pc;
            w_state = S_SQUASH;
          end else begin
            w_state = S_FETCH;
          end
        end
        S_HOLD: begin
          if (bus.redirect_valid || bus.instr_ready) begin
            w_pc    = bus.redirect_valid ? w_redir_pc : r_pc;
            w_valid = 1'b0;
            w_req   = 1'b1;
            w_addr  = w_pc;
            w_state = S_FETCH;
          end else begin
            w_state = S_HOLD;
          end
        end
        S_SQUASH: begin
          // The wrong-path request must complete before the new pc is fetched.
          w_pc = bus.redirect_valid ? w_redir_pc : r_pc;
          if (w_ack) begin
            w_req   = 1'b0;
            w_state = S_FETCH;
          end else begin
            w_state = S_SQUASH;
          end
        end
        S_ERROR: begin
          w_state = S_ERROR;
        end
        default: begin
          w_req   = 1'b0;
          w_valid = 1'b0;
          w_state = S_ERROR;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_FETCH;
      r_pc       <= RESET_PC;
      r_addr     <= RESET_PC;
      r_instr    <= 32'h0000_0000;
      r_instr_pc <= 32'h0000_0000;
      r_req      <= 1'b0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_wait_cnt <= 8'd0;
    end else begin
      r_state    <= w_state;
      r_pc       <= w_pc;
      r_addr     <= w_addr;
      r_instr    <= w_instr;
      r_instr_pc <= w_instr_pc;
      r_req      <= w_req;
      r_valid    <= w_valid;
      r_err      <= w_err;
      r_wait_cnt <= w_wait_cnt;
    end
  end

  assign bus.imem_req    = r_req;
  assign bus.imem_addr   = r_addr;
  assign bus.instruction = r_instr;
  assign bus.instr_pc    = r_instr_pc;
  assign bus.instr_valid = r_valid;
  assign bus.fetch_err   = r_err;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed steps, then randomized traffic checked
// against an architectural model (expected next delivered pc plus a fixed memory image).
module tb_instr_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_fetch_if ifc();

  instr_fetch_unit #(.RESET_PC(RST_PC), .MAX_WAIT(32'd15)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (ifc)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [31:0] exp_pc   = RST_PC;
  logic [31:0] acc_pc[$];
  int          acc_cyc[$];
  logic        req_seen = 1'b0;
  int          lat_left = 0;
  int          fix_lat  = 0;
  logic        rand_lat = 1'b0;
  logic        never_ack = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_010C) return 32'h2009_0005;
    else return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  // Memory model: answers each request after its chosen latency with the image word.
  task automatic drive_mem();
    if (ifc.imem_req) begin
      if (!req_seen) begin
        req_seen = 1'b1;
        lat_left = rand_lat ? int'($urandom_range(4, 0)) : fix_lat;
      end
      ifc.imem_ack = (lat_left == 0) && !never_ack;
    end else begin
      req_seen = 1'b0;
      ifc.imem_ack = 1'b0;
    end
    ifc.imem_rdata = ifc.imem_ack ? mem_word(ifc.imem_addr) : 32'hDEAD_BEEF;
  endtask

  task automatic tick();
    logic pend, hold;
    logic [31:0] paddr, pinstr, ppc;
    pend   = ifc.imem_req && !ifc.imem_ack && !rst && !never_ack;
    hold   = ifc.instr_valid && !ifc.instr_ready && !ifc.redirect_valid && !rst;
    paddr  = ifc.imem_addr;
    pinstr = ifc.instruction;
    ppc    = ifc.instr_pc;
    if (rst) begin
      exp_pc = RST_PC;
    end else if (ifc.redirect_valid) begin
      exp_pc = {ifc.redirect_pc[31:2], 2'b00};
    end else if (ifc.instr_valid && ifc.instr_ready) begin
      chk("accept_pc", ifc.instr_pc, exp_pc);
      chk("accept_word", ifc.instruction, mem_word(exp_pc));
      acc_pc.push_back(ifc.instr_pc);
      acc_cyc.push_back(cyc);
      exp_pc = exp_pc + 32'd4;
    end
    if (ifc.imem_req && ifc.imem_ack) req_seen = 1'b0;
    else if (ifc.imem_req) lat_left--;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (pend) begin
      chk("req_held", {31'd0, ifc.imem_req}, 32'd1);
      chk("addr_stable", ifc.imem_addr, paddr);
    end
    if (hold) begin
      chk("hold_valid", {31'd0, ifc.instr_valid}, 32'd1);
      chk("hold_instr", ifc.instruction, pinstr);
      chk("hold_pc", ifc.instr_pc, ppc);
    end
    drive_mem();
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!ifc.instr_valid && n < 50) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, ifc.instr_valid}, 32'd1);
  endtask

  initial begin
    int n;
    int base;
    rst = 1'b1;
    ifc.instr_ready = 1'b1;
    ifc.redirect_valid = 1'b0;
    ifc.redirect_pc = 32'h0;
    drive_mem();
    tick();
    tick();
    // Reset state.
    chk("rst_req", {31'd0, ifc.imem_req}, 32'd0);
    chk("rst_addr", ifc.imem_addr, RST_PC);
    chk("rst_instr", ifc.instruction, 32'h0);
    chk("rst_ipc", ifc.instr_pc, 32'h0);
    chk("rst_valid", {31'd0, ifc.instr_valid}, 32'd0);
    chk("rst_err", {31'd0, ifc.fetch_err}, 32'd0);
    rst = 1'b0;
    tick();
    chk("first_req", {31'd0, ifc.imem_req}, 32'd1);
    chk("first_addr", ifc.imem_addr, RST_PC);

    // Zero-wait streaming, one word every two cycles.
    for (int i = 0; i < 30 && acc_pc.size() < 3; i++) tick();
    chk("t1_count", acc_pc.size(), 32'd3);
    if (acc_pc.size() >= 3) begin
      chk("t1_pc0", acc_pc[0], 32'h100);
      chk("t1_pc1", acc_pc[1], 32'h104);
      chk("t1_pc2", acc_pc[2], 32'h108);
      chk("t1_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd2);
      chk("t1_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd2);
    end

    // Decoder stalls with a word held.
    ifc.instr_ready = 1'b0;
    wait_valid("t2_valid");
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_instr", ifc.instruction, 32'h2009_0005);
      chk("t2_ipc", ifc.instr_pc, 32'h10C);
      chk("t2_req", {31'd0, ifc.imem_req}, 32'd0);
    end
    fix_lat = 3;
    ifc.instr_ready = 1'b1;
    tick();
    chk("t2_accepted", {31'd0, ifc.instr_valid}, 32'd0);

    // Redirect while a delayed fetch is outstanding.
    chk("t3_req", {31'd0, ifc.imem_req}, 32'd1);
    chk("t3_addr", ifc.imem_addr, 32'h110);
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc = 32'h400;
    fix_lat = 0;
    tick();
    ifc.redirect_valid = 1'b0;
    n = 0;
    while (ifc.imem_req && n < 10) begin
      chk("t3_old_addr", ifc.imem_addr, 32'h110);
      chk("t3_no_valid", {31'd0, ifc.instr_valid}, 32'd0);
      tick();
      n++;
    end
    chk("t3_wait_cycles", n, 32'd3);
    chk("t3_gap_valid", {31'd0, ifc.instr_valid}, 32'd0);
    tick();
    chk("t3_new_req", {31'd0, ifc.imem_req}, 32'd1);
    chk("t3_new_addr", ifc.imem_addr, 32'h400);
    wait_valid("t3_valid");
    chk("t3_ipc", ifc.instr_pc, 32'h400);
    tick();

    // Redirect in HOLD together with ready drops the held word.
    ifc.instr_ready = 1'b0;
    wait_valid("t4_hold");
    chk("t4_held_pc", ifc.instr_pc, 32'h404);
    ifc.instr_ready = 1'b1;
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc = 32'h403;
    tick();
    ifc.redirect_valid = 1'b0;
    chk("t4_dropped", {31'd0, ifc.instr_valid}, 32'd0);
    wait_valid("t4_valid");
    chk("t4_ipc", ifc.instr_pc, 32'h400);
    chk("t4_word", ifc.instruction, mem_word(32'h400));
    tick();

    // PC wraps from the top of the address space.
    ifc.instr_ready = 1'b0;
    wait_valid("t5_hold");
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc = 32'hFFFF_FFFC;
    tick();
    ifc.redirect_valid = 1'b0;
    ifc.instr_ready = 1'b1;
    wait_valid("t5_valid_top");
    chk("t5_ipc_top", ifc.instr_pc, 32'hFFFF_FFFC);
    tick();
    chk("t5_wrap_req", {31'd0, ifc.imem_req}, 32'd1);
    chk("t5_wrap_addr", ifc.imem_addr, 32'h0);
    wait_valid("t5_valid_zero");
    chk("t5_ipc_zero", ifc.instr_pc, 32'h0);
    tick();

    // Randomized traffic against the model.
    rand_lat = 1'b1;
    base = acc_pc.size();
    for (int i = 0; i < 400; i++) begin
      ifc.instr_ready = ($urandom_range(9, 0) < 7);
      if ($urandom_range(19, 0) == 0) begin
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc = $urandom;
      end else begin
        ifc.redirect_valid = 1'b0;
      end
      tick();
    end
    ifc.redirect_valid = 1'b0;
    chk("rand_no_err", {31'd0, ifc.fetch_err}, 32'd0);
    chk("rand_progress", {31'd0, (acc_pc.size() - base) >= 30}, 32'd1);

    // Reset mid-stream, then memory that never answers.
    rst = 1'b1;
    tick();
    chk("mid_rst_req", {31'd0, ifc.imem_req}, 32'd0);
    chk("mid_rst_valid", {31'd0, ifc.instr_valid}, 32'd0);
    chk("mid_rst_addr", ifc.imem_addr, RST_PC);
    never_ack = 1'b1;
    ifc.instr_ready = 1'b1;
    tick();
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 40 && !ifc.fetch_err; i++) begin
      if (ifc.imem_req) n++;
      tick();
    end
    chk("t6_err", {31'd0, ifc.fetch_err}, 32'd1);
    chk("t6_req_cycles", n, 32'd15);
    chk("t6_req_low", {31'd0, ifc.imem_req}, 32'd0);
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc = 32'h800;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_static_req", {31'd0, ifc.imem_req}, 32'd0);
      chk("t6_static_addr", ifc.imem_addr, RST_PC);
      chk("t6_sticky", {31'd0, ifc.fetch_err}, 32'd1);
    end
    ifc.redirect_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("t6_err_clear", {31'd0, ifc.fetch_err}, 32'd0);
    never_ack = 1'b0;
    rst = 1'b0;
    tick();
    chk("t6_restart_req", {31'd0, ifc.imem_req}, 32'd1);
    chk("t6_restart_addr", ifc.imem_addr, RST_PC);
    wait_valid("t6_valid");
    chk("t6_ipc", ifc.instr_pc, RST_PC);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
